apb3_cmd_master: RTL and testbench

APB3_CMD_MASTER -- requirements
Module: apb3_cmd_master

---
 rtl/apb3_cmd_master.sv | 148 ++++++++++++++
 tb/tb_apb3_cmd_master.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb3_cmd_master.sv
// rtl/apb3_cmd_master.sv - command/response front end driving an APB3 master port
//
// Accepts one command at a time on a valid/ready interface, runs it as an APB3
// SETUP/ACCESS transfer on the selected slave, and returns the read data or an
// error on a valid/ready response interface.
//
// Ports:
//   clk, rst                  single rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready       command handshake (ready only while idle)
//   cmd_write, cmd_slave,
//   cmd_addr, cmd_wdata       command fields, captured on the handshake
//   rsp_valid/rsp_ready       response handshake
//   rsp_rdata, rsp_error      read data (0 for writes/errors), timeout or bad-slave flag
//   apb3_paddr..apb3_pwdata   APB3 master outputs, one-hot psel
//   apb3_pready, apb3_prdata  per-slave APB3 inputs; only the selected slave is used
module apb3_cmd_master #(
    parameter int APB_ADDR_WIDTH_P   = 16,
    parameter int APB_DATA_WIDTH_P   = 32,
    parameter int APB_NR_OF_SLAVES_P = 2,
    parameter int TIMEOUT_P          = 256
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic                                                 cmd_valid,
    output logic                                                 cmd_ready,
    input  logic                                                 cmd_write,
    input  logic [7:0]                                           cmd_slave,
    input  logic [APB_ADDR_WIDTH_P-1:0]                          cmd_addr,
    input  logic [APB_DATA_WIDTH_P-1:0]                          cmd_wdata,
    output logic                                                 rsp_valid,
    input  logic                                                 rsp_ready,
    output logic [APB_DATA_WIDTH_P-1:0]                          rsp_rdata,
    output logic                                                 rsp_error,
    output logic [APB_ADDR_WIDTH_P-1:0]                          apb3_paddr,
    output logic [APB_NR_OF_SLAVES_P-1:0]                        apb3_psel,
    output logic                                                 apb3_penable,
    output logic                                                 apb3_pwrite,
    output logic [APB_DATA_WIDTH_P-1:0]                          apb3_pwdata,
    input  logic [APB_NR_OF_SLAVES_P-1:0]                        apb3_pready,
    input  logic [APB_NR_OF_SLAVES_P-1:0][APB_DATA_WIDTH_P-1:0]  apb3_prdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [8:0]  NR_SLAVES    = 9'(APB_NR_OF_SLAVES_P);
    // The counter holds the number of completed ACCESS cycles, so the
    // TIMEOUT_P-th ACCESS cycle is the one where it reads TIMEOUT_P-1.
    localparam logic [15:0] LAST_ACC_CNT = 16'(TIMEOUT_P - 1);

    state_t                         state;
    state_t                         state_nxt;
    logic [15:0]                    acc_cnt;
    logic [7:0]                     slave_q;
    logic                           slave_ok;
    logic                           timeout;
    logic [APB_NR_OF_SLAVES_P-1:0]  sel_onehot;
    logic                           sel_ready;
    logic [APB_DATA_WIDTH_P-1:0]    sel_rdata;

    assign slave_ok = ({1'b0, cmd_slave} < NR_SLAVES);
    assign timeout  = (acc_cnt == LAST_ACC_CNT);

    // Decode the registered slave index once; pready/prdata of every other
    // slave never reach the datapath.
    always_comb begin
        sel_onehot = '0;
        sel_ready  = 1'b0;
        sel_rdata  = '0;
        for (int i = 0; i < APB_NR_OF_SLAVES_P; i++) begin
            if (slave_q == 8'(i)) begin
                sel_onehot[i] = 1'b1;
                sel_ready     = apb3_pready[i];
                sel_rdata     = apb3_prdata[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid) state_nxt = slave_ok ? SETUP : RESP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (sel_ready || timeout) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_cnt     <= '0;
            slave_q     <= '0;
            apb3_paddr  <= '0;
            apb3_pwrite <= 1'b0;
            apb3_pwdata <= '0;
            rsp_rdata   <= '0;
            rsp_error   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        slave_q     <= cmd_slave;
                        apb3_paddr  <= cmd_addr;
                        apb3_pwrite <= cmd_write;
                        apb3_pwdata <= cmd_wdata;
                        acc_cnt     <= '0;
                        if (!slave_ok) begin
                            rsp_error <= 1'b1;
                            rsp_rdata <= '0;
                        end
                    end
                end
                ACCESS: begin
                    acc_cnt <= acc_cnt + 16'd1;
                    // A ready on the final allowed cycle still wins over timeout.
                    if (sel_ready) begin
                        rsp_error <= 1'b0;
                        rsp_rdata <= apb3_pwrite ? '0 : sel_rdata;
                    end else if (timeout) begin
                        rsp_error <= 1'b1;
                        rsp_rdata <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // cmd_ready is masked by rst so it reads 0 for the whole reset pulse.
    assign cmd_ready    = (state == IDLE) && !rst;
    assign rsp_valid    = (state == RESP);
    assign apb3_psel    = ((state == SETUP) || (state == ACCESS)) ? sel_onehot : '0;
    assign apb3_penable = (state == ACCESS);

endmodule

// File: tb/tb_apb3_cmd_master.sv
// tb/tb_apb3_cmd_master.sv - scoreboard bench for apb3_cmd_master
module tb_apb3_cmd_master;

    localparam int T     = 8;
    localparam int NEVER = 1000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_write = 1'b0;
    logic [7:0]        cmd_slave = '0;
    logic [15:0]       cmd_addr = '0;
    logic [31:0]       cmd_wdata = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [31:0]       rsp_rdata;
    logic              rsp_error;
    logic [15:0]       paddr;
    logic [1:0]        psel;
    logic              penable;
    logic              pwrite;
    logic [31:0]       pwdata;
    logic [1:0]        pready = '0;
    logic [1:0][31:0]  prdata = '0;

    apb3_cmd_master #(
        .APB_ADDR_WIDTH_P   (16),
        .APB_DATA_WIDTH_P   (32),
        .APB_NR_OF_SLAVES_P (2),
        .TIMEOUT_P          (T)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_slave    (cmd_slave),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_error    (rsp_error),
        .apb3_paddr   (paddr),
        .apb3_psel    (psel),
        .apb3_penable (penable),
        .apb3_pwrite  (pwrite),
        .apb3_pwdata  (pwdata),
        .apb3_pready  (pready),
        .apb3_prdata  (prdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    typedef struct {
        int          slave;
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        int          w;
        logic [31:0] rd;
        logic [31:0] noise;
        int          acc;
    } cfg_t;

    exp_t sbq[$];
    cfg_t slq[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   hold_req = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Slave emulation: pops the configuration of each transfer at SETUP,
    // checks the APB outputs, and drives pready/prdata for the next edge.
    cfg_t scfg;
    bit   s_active = 1'b0;
    int   s_acc = 0;
    always @(negedge clk) begin
        logic [1:0] oh;
        if (rst) begin
            s_active = 1'b0;
            slq.delete();
        end else if (psel != 2'b00 && !penable) begin
            if (slq.size() == 0) begin
                chk("psel_without_valid_cmd", 64'(psel), 64'd0);
            end else begin
                scfg     = slq.pop_front();
                s_active = 1'b1;
                s_acc    = 0;
                oh = '0;
                oh[scfg.slave] = 1'b1;
                chk("setup_psel", 64'(psel), 64'(oh));
                chk("setup_paddr", 64'(paddr), 64'(scfg.addr));
                chk("setup_pwrite", 64'(pwrite), 64'(scfg.wr));
                chk("setup_pwdata", 64'(pwdata), 64'(scfg.wdata));
            end
        end else if (penable) begin
            s_acc++;
            oh = '0;
            if (s_active) oh[scfg.slave] = 1'b1;
            chk("access_psel", 64'(psel), 64'(oh));
            chk("access_paddr", 64'(paddr), 64'(scfg.addr));
            chk("access_pwdata", 64'(pwdata), 64'(scfg.wdata));
        end else if (s_active) begin
            chk("access_cycles", 64'(s_acc), 64'(scfg.acc));
            s_active = 1'b0;
        end
        pready    = 2'($urandom);
        prdata[0] = $urandom;
        prdata[1] = $urandom;
        if (s_active) begin
            for (int i = 0; i < 2; i++) prdata[i] = (i == scfg.slave) ? scfg.rd : scfg.noise;
            pready[scfg.slave] = penable && (s_acc == scfg.w + 1);
        end
    end

    // Response monitor: measures handshake-to-response latency, pops the
    // scoreboard on each new response, checks stability while held, and
    // drives rsp_ready.
    exp_t cur;
    bit   in_rsp = 1'b0;
    int   lat = 0;
    int   hold_left = 0;
    always @(negedge clk) begin
        if (rst) begin
            sbq.delete();
            in_rsp    = 1'b0;
            rsp_ready = 1'b0;
            hold_left = 0;
        end else begin
            lat++;
            if (penable) chk("penable_needs_psel", 64'(psel != 2'b00), 64'd1);
            if (rsp_valid) begin
                if (!in_rsp) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_rsp_valid", 64'(rsp_valid), 64'd0);
                    end else begin
                        cur    = sbq.pop_front();
                        in_rsp = 1'b1;
                        chk("rsp_latency", 64'(lat), 64'(cur.lat));
                        if (hold_req) begin
                            hold_left = 10;
                            hold_req  = 1'b0;
                        end
                    end
                end
                if (in_rsp) begin
                    chk("rsp_rdata", 64'(rsp_rdata), 64'(cur.rdata));
                    chk("rsp_error", 64'(rsp_error), 64'(cur.err));
                    chk("cmd_ready_in_resp", 64'(cmd_ready), 64'd0);
                    chk("psel_in_resp", 64'({psel, penable}), 64'd0);
                end
                if (hold_left > 0) begin
                    rsp_ready = 1'b0;
                    hold_left--;
                end else begin
                    rsp_ready = ($urandom_range(0, 1) == 1);
                end
                if (rsp_ready) in_rsp = 1'b0;
            end else begin
                rsp_ready = ($urandom_range(0, 1) == 1);
            end
            if (cmd_valid && cmd_ready) lat = 0;
        end
    end

    // Reference model of one command: decides error/data/latency from the
    // slave index and the number of wait states the slave will insert.
    task automatic issue(input logic wr, input int sl, input logic [15:0] a,
                         input logic [31:0] d, input int w, input logic [31:0] rd,
                         input logic [31:0] noise);
        exp_t e;
        cfg_t c;
        int   n;
        @(posedge clk);
        #1;
        cmd_write = wr;
        cmd_slave = 8'(sl);
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            chk("cmd_accept_timeout", 64'(cmd_ready), 64'd1);
        end else begin
            if (sl >= 2) begin
                e = '{err: 1'b1, rdata: 32'd0, lat: 1};
            end else begin
                c = '{slave: sl, wr: wr, addr: a, wdata: d, w: w, rd: rd, noise: noise, acc: 0};
                if (w + 1 <= T) begin
                    e = '{err: 1'b0, rdata: (wr ? 32'd0 : rd), lat: 3 + w};
                    c.acc = w + 1;
                end else begin
                    e = '{err: 1'b1, rdata: 32'd0, lat: 2 + T};
                    c.acc = T;
                end
                slq.push_back(c);
            end
            sbq.push_back(e);
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_slave = 8'($urandom);
        cmd_addr  = 16'($urandom);
        cmd_wdata = $urandom;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!(sbq.size() == 0 && !rsp_valid && cmd_ready) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_idle", 64'(sbq.size()), 64'd0);
    endtask

    initial begin
        int wsel[7];
        wsel = '{0, 1, 2, 3, 7, 8, NEVER};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("reset_rsp_error", 64'(rsp_error), 64'd0);
        chk("reset_psel", 64'(psel), 64'd0);
        chk("reset_penable", 64'(penable), 64'd0);
        chk("reset_paddr", 64'(paddr), 64'd0);
        chk("reset_pwrite", 64'(pwrite), 64'd0);
        chk("reset_pwdata", 64'(pwdata), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("cmd_ready_after_reset", 64'(cmd_ready), 64'd1);

        // zero-wait write to slave 1
        issue(1'b1, 1, 16'h0010, 32'h0000_1234, 0, 32'h0, $urandom);
        // read slave 0 with 3 wait states, other slave shows all ones
        issue(1'b0, 0, 16'h0200, $urandom, 3, 32'hCAFE_F00D, 32'hFFFF_FFFF);
        // slave never ready: timeout after T ACCESS cycles
        issue(1'b0, 1, 16'h0300, $urandom, NEVER, 32'h1111_2222, $urandom);
        // ready on the last allowed ACCESS cycle still succeeds
        issue(1'b0, 0, 16'h0304, $urandom, T - 1, 32'h0BAD_BEEF, $urandom);
        // bad slave index
        issue(1'b1, 5, 16'h0400, $urandom, 0, 32'h0, $urandom);

        // response held for 10 cycles while another command waits
        wait_idle();
        hold_req = 1'b1;
        issue(1'b0, 0, 16'h0500, $urandom, 1, 32'h5A5A_A5A5, $urandom);
        issue(1'b1, 1, 16'h0504, 32'h7777_0000, 0, 32'h0, $urandom);

        // reset during the 2nd ACCESS cycle
        wait_idle();
        issue(1'b0, 0, 16'h0600, $urandom, 5, 32'h0000_0077, $urandom);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_psel", 64'(psel), 64'd0);
        chk("rst_mid_penable", 64'(penable), 64'd0);
        chk("rst_mid_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_mid_cmd_ready", 64'(cmd_ready), 64'd1);
        repeat (4) begin
            @(negedge clk);
            chk("rst_no_response", 64'(rsp_valid), 64'd0);
        end

        // randomized traffic
        for (int k = 0; k < 40; k++) begin
            int sl;
            sl = ($urandom_range(0, 5) == 0) ? int'($urandom_range(2, 255)) : int'($urandom_range(0, 1));
            issue(1'($urandom), sl, 16'($urandom), $urandom, wsel[$urandom_range(0, 6)],
                  $urandom, $urandom);
        end
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
